// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package mem_arb_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // First byte address past the data region.
  localparam logic [31:0] DATA_LIMIT_DEFAULT = 32'h0000_3000;

  // Rejects misaligned words and anything outside the data region.
  function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] limit);
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: when both request, favour the one not granted last.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_valid
);

  // Pure combinational selection; the caller owns the last_grant register.
  always_comb begin
    any_valid = |valid;
    grant     = 1'b0;
    case (valid)
      2'b11:   grant = ~last_grant;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data port of the unified instruction/data memory between the
// CPU load/store stage (req0) and the DMA/debug loader (req1). Each access is
// a fixed-length strobe window followed by one deasserted recovery cycle so
// that every write sees a fresh rising edge.
// Optional build macro: MEM_ARB_STATS_EN adds grant/error counters.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] DATA_LIMIT    = DATA_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_err,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_err,
  output logic [31:0] req1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  arb_state_t  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        accept;
  logic        access_end;

  logic [1:0]  valid_vec;
  logic [1:0]  write_vec;
  logic [31:0] addr_vec  [2];
  logic [31:0] wdata_vec [2];
  logic        grant, any_valid;
  logic        sel_write, sel_bad;
  logic [31:0] sel_addr, sel_wdata;

  logic        owner_reg, last_grant_reg, wr_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic        mem_read_reg, mem_write_reg;

  logic [1:0]  ready_vec, done_vec, err_vec;
  logic [31:0] rdata_vec [2];

  assign valid_vec    = {req1_valid, req0_valid};
  assign write_vec    = {req1_write, req0_write};
  assign addr_vec[0]  = req0_addr;
  assign addr_vec[1]  = req1_addr;
  assign wdata_vec[0] = req0_wdata;
  assign wdata_vec[1] = req1_wdata;

  rr_arbiter_2 u_rr (
    .valid      (valid_vec),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  assign sel_write  = write_vec[grant];
  assign sel_addr   = addr_vec[grant];
  assign sel_wdata  = wdata_vec[grant];
  assign sel_bad    = addr_bad(sel_addr, DATA_LIMIT);
  assign access_end = (state_reg == ACCESS) && (cnt_reg == 4'd0);

  // State and window counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; requests are only looked at while idle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          accept = 1'b1;
          if (sel_bad) begin
            state_next = DONE;
          end else begin
            state_next = ACCESS;
            cnt_next   = CNT_INIT;
          end
        end
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) state_next = RECOVER;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RECOVER: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latches the accepted request and drives registered memory strobes.
  // Address/data are only reloaded on a good accept so they never move
  // inside a strobe window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      wr_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
    end else if (accept) begin
      owner_reg      <= grant;
      last_grant_reg <= grant;
      wr_reg         <= sel_write;
      if (!sel_bad) begin
        addr_reg      <= sel_addr;
        wdata_reg     <= sel_wdata;
        mem_write_reg <= sel_write;
        mem_read_reg  <= ~sel_write;
      end
    end else if (access_end) begin
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
    end
  end

  // Per-requester handshake and result registers; a requester's results only
  // move when it owns the current transaction.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic        ready_reg, done_reg, err_reg;
      logic [31:0] rdata_reg;
      logic        mine_now, mine_owner;

      assign mine_now   = (grant == 1'(gi));
      assign mine_owner = (owner_reg == 1'(gi));

      // Ready on accept, done on leaving RECOVER or straight after a rejected accept.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ready_reg <= 1'b0;
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          ready_reg <= accept && mine_now;
          done_reg  <= (accept && sel_bad && mine_now) ||
                       ((state_reg == RECOVER) && mine_owner);
          if (accept && sel_bad && mine_now) begin
            err_reg   <= 1'b1;
            rdata_reg <= '0;
          end else if ((state_reg == RECOVER) && mine_owner) begin
            err_reg <= 1'b0;
          end
          if (access_end && !wr_reg && mine_owner) rdata_reg <= mem_rdata;
        end
      end

      assign ready_vec[gi] = ready_reg;
      assign done_vec[gi]  = done_reg;
      assign err_vec[gi]   = err_reg;
      assign rdata_vec[gi] = rdata_reg;
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign req0_done  = done_vec[0];
  assign req1_done  = done_vec[1];
  assign req0_err   = err_vec[0];
  assign req1_err   = err_vec[1];
  assign req0_rdata = rdata_vec[0];
  assign req1_rdata = rdata_vec[1];
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_read   = mem_read_reg;
  assign mem_write  = mem_write_reg;
  assign busy       = (state_reg != IDLE);

`ifdef MEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0_reg, gnt_cnt1_reg, err_cnt_reg;

  // Saturating grant and error counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt0_reg <= '0;
      gnt_cnt1_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      if (ready_vec[0] && (gnt_cnt0_reg != 16'hFFFF)) gnt_cnt0_reg <= gnt_cnt0_reg + 16'd1;
      if (ready_vec[1] && (gnt_cnt1_reg != 16'hFFFF)) gnt_cnt1_reg <= gnt_cnt1_reg + 16'd1;
      if (((done_vec & err_vec) != 2'b00) && (err_cnt_reg != 16'hFFFF))
        err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_reg;
  assign gnt_cnt1 = gnt_cnt1_reg;
  assign err_cnt  = err_cnt_reg;
`endif

endmodule
